// File: rtl/rank_frame_sched_if.sv
// Source and result handshake bundle for rank_frame_sched.
interface rank_frame_sched_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_last;
  logic              s0_ready;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_last;
  logic              s1_ready;
  logic              res_valid;
  logic              res_ready;
  logic              res_src;
  logic [DATA_W-1:0] res_max;
  logic [DATA_W-1:0] res_second;
  logic              res_second_vld;
  logic [CNT_W-1:0]  res_count;

  modport master (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, res_ready,
    input  s0_ready, s1_ready, res_valid, res_src, res_max, res_second,
           res_second_vld, res_count
  );

  modport slave (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, res_ready,
    output s0_ready, s1_ready, res_valid, res_src, res_max, res_second,
           res_second_vld, res_count
  );
endinterface

// File: rtl/rank_frame_sched.sv
// Round-robin, frame-granular sharing of one top-two rank tracker between two
// framed sample streams; each frame's max/second/count is reported per source.
module rank_frame_sched #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  rank_frame_sched_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] sec_q, sec_d;
  logic              sec_vld_q, sec_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      max_q        <= '0;
      sec_q        <= '0;
      sec_vld_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      max_q        <= max_d;
      sec_q        <= sec_d;
      sec_vld_q    <= sec_vld_d;
      cnt_q        <= cnt_d;
    end
  end

  // last_grant doubles as the current-frame owner while in ACCUM/REPORT.
  always_comb begin
    sel_valid = last_grant_q ? io.s1_valid : io.s0_valid;
    sel_last  = last_grant_q ? io.s1_last  : io.s0_last;
    sel_data  = last_grant_q ? io.s1_data  : io.s0_data;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    max_d        = max_q;
    sec_d        = sec_q;
    sec_vld_d    = sec_vld_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (io.s0_valid && (!io.s1_valid || last_grant_q)) begin
          state_d      = ACCUM;
          last_grant_d = 1'b0;
        end else if (io.s1_valid) begin
          state_d      = ACCUM;
          last_grant_d = 1'b1;
        end
      end
      ACCUM: begin
        if (sel_valid) begin
          // A zero count marks the first beat; it saturates, so never wraps back.
          if (cnt_q == '0) begin
            max_d     = sel_data;
            sec_d     = '0;
            sec_vld_d = 1'b0;
          end else if (sel_data > max_q) begin
            sec_d     = max_q;
            sec_vld_d = 1'b1;
            max_d     = sel_data;
          end else if ((sel_data < max_q) && (!sec_vld_q || (sel_data > sec_q))) begin
            sec_d     = sel_data;
            sec_vld_d = 1'b1;
          end
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (sel_last) state_d = REPORT;
        end
      end
      REPORT: begin
        if (io.res_ready) begin
          state_d   = IDLE;
          max_d     = '0;
          sec_d     = '0;
          sec_vld_d = 1'b0;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.s0_ready       = 1'b0;
    io.s1_ready       = 1'b0;
    io.res_valid      = 1'b0;
    io.res_src        = 1'b0;
    io.res_max        = '0;
    io.res_second     = '0;
    io.res_second_vld = 1'b0;
    io.res_count      = '0;
    if (state_q == ACCUM) begin
      io.s0_ready = !last_grant_q;
      io.s1_ready = last_grant_q;
    end
    if (state_q == REPORT) begin
      io.res_valid      = 1'b1;
      io.res_src        = last_grant_q;
      io.res_max        = max_q;
      io.res_second     = sec_vld_q ? sec_q : '0;
      io.res_second_vld = sec_vld_q;
      io.res_count      = cnt_q;
    end
  end

endmodule

// File: tb/tb_rank_frame_sched.sv
// Self-checking bench for rank_frame_sched: directed frame table, hand-written
// stall/reset sequences, and randomized frames against a frame-level model.
module tb_rank_frame_sched;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rank_frame_sched_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  rank_frame_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct packed {
    logic        src;
    logic [3:0]  len;
    logic [63:0] d;      // beat i at d[i*8 +: 8]
    logic [7:0]  emax;
    logic [7:0]  esec;
    logic        evld;
    logic [3:0]  ecnt;
  } vec_t;

  typedef struct packed {
    logic [7:0]       mx;
    logic [7:0]       sc;
    logic             vld;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input bit s, input logic v, input logic [7:0] d, input logic l);
    if (!s) begin
      bus.s0_valid = v; bus.s0_data = d; bus.s0_last = l;
    end else begin
      bus.s1_valid = v; bus.s1_data = d; bus.s1_last = l;
    end
  endtask

  function automatic logic get_ready(input bit s);
    return s ? bus.s1_ready : bus.s0_ready;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_s0_ready"}, 32'(bus.s0_ready), 0);
    chk({tag, "_s1_ready"}, 32'(bus.s1_ready), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_res_src"}, 32'(bus.res_src), 0);
    chk({tag, "_res_max"}, 32'(bus.res_max), 0);
    chk({tag, "_res_second"}, 32'(bus.res_second), 0);
    chk({tag, "_res_second_vld"}, 32'(bus.res_second_vld), 0);
    chk({tag, "_res_count"}, 32'(bus.res_count), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b1;
  endtask

  // Streams one frame; returns #1 after the edge that accepted the last beat.
  task automatic feed_frame(input bit s, input logic [63:0] d, input int unsigned len);
    int unsigned i = 0;
    int unsigned cyc = 0;
    logic r;
    while (i < len && cyc < 50) begin
      set_src(s, 1'b1, d[i*8 +: 8], (i == len - 1));
      r = get_ready(s);
      chk("other_ready", 32'(get_ready(!s)), 0);
      tick();
      cyc++;
      if (r) i++;
    end
    set_src(s, 0, 0, 0);
    if (i < len) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d beats expected %0d", i, len);
    end
  endtask

  task automatic run_rand(input int unsigned nf, input int unsigned minl, input int unsigned maxl,
                          input bit bubbles, input bit rr_rand);
    logic [7:0]  bd [2][$];
    bit          bl [2][$];
    exp_t        ex [2][$];
    bit          ord [$];
    logic [7:0]  vals [32];
    bit          infr [2];
    bit          vv [2];
    bit          rr [2];
    int unsigned n [2];
    int unsigned len, cmax, cyc;
    exp_t        e, held;
    bit          hold, h, lastg, pick;
    cmax = (1 << CNT_W) - 1;
    for (int s = 0; s < 2; s++) begin
      for (int unsigned f = 0; f < nf; f++) begin
        len = $urandom_range(maxl, minl);
        e = '0;
        for (int unsigned b = 0; b < len; b++) begin
          vals[b] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
          bd[s].push_back(vals[b]);
          bl[s].push_back(b == len - 1);
          if (vals[b] > e.mx) e.mx = vals[b];
        end
        for (int unsigned b = 0; b < len; b++)
          if (vals[b] < e.mx && (!e.vld || vals[b] > e.sc)) begin
            e.sc = vals[b];
            e.vld = 1'b1;
          end
        e.cnt = CNT_W'((len > cmax) ? cmax : len);
        ex[s].push_back(e);
      end
    end
    // Every source with frames left is valid whenever the scheduler is idle.
    n[0] = nf; n[1] = nf; lastg = 1'b1;
    while (n[0] + n[1] > 0) begin
      pick = (n[0] > 0 && (n[1] == 0 || lastg)) ? 1'b0 : 1'b1;
      ord.push_back(pick);
      n[pick]--;
      lastg = pick;
    end
    infr[0] = 0; infr[1] = 0; hold = 0; cyc = 0; held = '0;
    while (ord.size() > 0 && cyc < 20000) begin
      h = ord[0];
      for (int s = 0; s < 2; s++) begin
        if (bd[s].size() > 0) begin
          vv[s] = !bubbles || !infr[s] || ($urandom_range(0, 3) != 0);
          set_src(s[0], vv[s], bd[s][0], bl[s][0]);
        end else begin
          vv[s] = 0;
          set_src(s[0], 0, 0, 0);
        end
      end
      bus.res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      rr[0] = bus.s0_ready;
      rr[1] = bus.s1_ready;
      chk("cross_ready", 32'(rr[!h]), 0);
      if (bus.res_valid) begin
        if (!hold) begin
          e = ex[h][0];
          chk("rand_src", 32'(bus.res_src), 32'(h));
          chk("rand_max", 32'(bus.res_max), 32'(e.mx));
          chk("rand_second", 32'(bus.res_second), 32'(e.sc));
          chk("rand_second_vld", 32'(bus.res_second_vld), 32'(e.vld));
          chk("rand_count", 32'(bus.res_count), 32'(e.cnt));
        end else begin
          chk("stall_max", 32'(bus.res_max), 32'(held.mx));
          chk("stall_second", 32'(bus.res_second), 32'(held.sc));
          chk("stall_count", 32'(bus.res_count), 32'(held.cnt));
          chk("stall_src", 32'(bus.res_src), 32'(h));
        end
        held.mx = bus.res_max; held.sc = bus.res_second;
        held.vld = bus.res_second_vld; held.cnt = bus.res_count;
        if (bus.res_ready) begin
          void'(ex[h].pop_front());
          void'(ord.pop_front());
          hold = 0;
        end else begin
          hold = 1;
        end
      end
      tick();
      cyc++;
      for (int s = 0; s < 2; s++)
        if (vv[s] && rr[s]) begin
          infr[s] = !bl[s][0];
          void'(bd[s].pop_front());
          void'(bl[s].pop_front());
        end
    end
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    bus.res_ready = 1'b0;
    chk("rand_drain", 32'(ord.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    vecs[0] = '{1'b0, 4'd5, {24'h0, 8'h07, 8'h09, 8'h05, 8'h09, 8'h03}, 8'h09, 8'h07, 1'b1, 4'd5};
    vecs[1] = '{1'b1, 4'd3, {40'h0, 8'h04, 8'h04, 8'h04},                8'h04, 8'h00, 1'b0, 4'd3};
    vecs[2] = '{1'b0, 4'd1, {56'h0, 8'hFF},                              8'hFF, 8'h00, 1'b0, 4'd1};
    vecs[3] = '{1'b1, 4'd2, {48'h0, 8'h02, 8'h01},                       8'h02, 8'h01, 1'b1, 4'd2};
    vecs[4] = '{1'b0, 4'd5, {24'h0, 8'h00, 8'h04, 8'h03, 8'h03, 8'h05}, 8'h05, 8'h04, 1'b1, 4'd5};

    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feed_frame(vecs[i].src, vecs[i].d, 32'(vecs[i].len));
      chk("vec_latency_valid", 32'(bus.res_valid), 1);
      chk("vec_src", 32'(bus.res_src), 32'(vecs[i].src));
      chk("vec_max", 32'(bus.res_max), 32'(vecs[i].emax));
      chk("vec_second", 32'(bus.res_second), 32'(vecs[i].esec));
      chk("vec_second_vld", 32'(bus.res_second_vld), 32'(vecs[i].evld));
      chk("vec_count", 32'(bus.res_count), 32'(vecs[i].ecnt));
      tick();
      chk("vec_res_done", 32'(bus.res_valid), 0);
    end

    // Result back-pressure: fields hold, no beats taken, IDLE after handshake.
    bus.res_ready = 1'b0;
    feed_frame(1'b0, {48'h0, 8'h02, 8'h06}, 2);
    set_src(0, 1, 8'hEE, 0);
    set_src(1, 1, 8'hEE, 0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 32'(bus.res_valid), 1);
      chk("hold_max", 32'(bus.res_max), 32'h06);
      chk("hold_second", 32'(bus.res_second), 32'h02);
      chk("hold_count", 32'(bus.res_count), 2);
      chk("hold_s0_ready", 32'(bus.s0_ready), 0);
      chk("hold_s1_ready", 32'(bus.s1_ready), 0);
      tick();
    end
    chk("hold_valid_last", 32'(bus.res_valid), 1);
    chk("hold_count_last", 32'(bus.res_count), 2);
    bus.res_ready = 1'b1;
    tick();
    chk("post_hs_valid", 32'(bus.res_valid), 0);
    chk("post_hs_s0_ready", 32'(bus.s0_ready), 0);
    chk("post_hs_s1_ready", 32'(bus.s1_ready), 0);
    tick();
    chk("post_hs_grant_s1", 32'(bus.s1_ready), 1);
    chk("post_hs_no_s0", 32'(bus.s0_ready), 0);

    // Reset in the middle of an s1 frame discards it.
    do_reset();
    bus.res_ready = 1'b1;
    set_src(1, 1, 8'd200, 0);
    begin
      int unsigned got = 0;
      for (int k = 0; k < 10 && got < 2; k++) begin
        if (bus.s1_ready) got++;
        tick();
      end
      chk("midreset_beats", got, 2);
    end
    reset = 1'b0;
    tick();
    chk_zero("midreset");
    reset = 1'b1;
    set_src(0, 1, 8'd5, 1);
    set_src(1, 1, 8'd200, 0);
    tick();
    chk("midreset_grant_s0", 32'(bus.s0_ready), 1);
    chk("midreset_no_s1", 32'(bus.s1_ready), 0);
    chk("midreset_no_stale", 32'(bus.res_valid), 0);
    tick();
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    chk("midreset_res_valid", 32'(bus.res_valid), 1);
    chk("midreset_res_src", 32'(bus.res_src), 0);
    chk("midreset_res_max", 32'(bus.res_max), 5);
    chk("midreset_res_vld", 32'(bus.res_second_vld), 0);
    chk("midreset_res_count", 32'(bus.res_count), 1);

    // Contention with 2-beat frames: strict s0,s1,s0,... alternation.
    do_reset();
    run_rand(3, 2, 2, 1'b0, 1'b0);

    // Random frames with bubbles, back-pressure and count saturation.
    do_reset();
    run_rand(8, 1, 20, 1'b1, 1'b1);
    do_reset();
    run_rand(6, 1, 6, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rank_frame_sched.md
Name: rank_frame_sched

Overview:
- Shares one running top-two rank tracker between two framed sample streams using round-robin, frame-granular arbitration.
- For each granted frame, computes the highest and second-highest distinct values and the beat count.
- Presents the result on a valid/ready result port, tagged with the source ID.
- Sits upstream of the stream-statistics readout, replacing per-source tracker instances.

Parameters:
- DATA_W, 8, sample width in bits (unsigned compare).
- CNT_W, 16, beat-counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous active-low reset.
- s0_valid  in  1  source 0 beat valid.
- s0_data  in  DATA_W  source 0 sample.
- s0_last  in  1  source 0 final beat of frame.
- s0_ready  out  1  source 0 beat accepted when s0_valid&s0_ready.
- s1_valid  in  1  source 1 beat valid.
- s1_data  in  DATA_W  source 1 sample.
- s1_last  in  1  source 1 final beat of frame.
- s1_ready  out  1  source 1 beat accepted when s1_valid&s1_ready.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_src  out  1  source ID of reported frame.
- res_max  out  DATA_W  highest value in frame.
- res_second  out  DATA_W  second-highest distinct value; 0 when res_second_vld=0.
- res_second_vld  out  1  frame held at least two distinct values.
- res_count  out  CNT_W  accepted beats in frame, saturating.

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0: s*_ready, res_valid, res_src, res_max, res_second, res_second_vld, res_count.
  - Tracker is cleared.
  - last_grant is set to 1, so s0 wins the first contention.
  - A reset mid-frame or mid-report discards everything; no partial result is emitted.
- FSM IDLE:
  - s*_ready=0.
  - Only s0_valid: grant 0.
  - Only s1_valid: grant 1.
  - Both valid: grant the source != last_grant.
  - On any grant, go to ACCUM next cycle and set last_grant to the granted source.
  - Neither valid: stay in IDLE.
- FSM ACCUM:
  - Ready is high only for the granted source; the other source's ready stays 0.
  - Each accepted beat updates the tracker and count in the same edge.
  - An accepted beat with last=1 moves the FSM to REPORT next cycle.
  - Beats with valid=0 are ignored. ACCUM has no timeout.
- FSM REPORT:
  - res_valid=1 with stable res_* fields; both readies are 0.
  - On res_valid&res_ready: clear the tracker and go to IDLE.
  - Fields hold unchanged while res_ready=0.
- Latency:
  - Source valid in IDLE to first ready: 1 cycle.
  - last beat accepted to res_valid: 1 cycle.
  - Result handshake to next grant decision: 1 cycle (IDLE).
- Tracker update for an accepted beat d (unsigned):
  - First beat of frame: max=d, sec_vld=0.
  - d>max: sec=max, sec_vld=1, max=d.
  - d<max and (sec_vld=0 or d>sec): sec=d, sec_vld=1.
  - d==max or d<=sec: no change. Duplicates never count as second.
- count:
  - Increments on every accepted beat and saturates at all-ones.
  - A single-beat frame reports count=1.
- A source may hold valid between frames; it is re-arbitrated each time the FSM is in IDLE.

Test Plan:
- s0 frame [3,9,5,9,7], last on 7, res_ready=1 -> res_max=9, res_second=7, res_second_vld=1, res_count=5, res_src=0; res_valid exactly 1 cycle after last beat.
- s1 frame [4,4,4] -> res_max=4, res_second_vld=0, res_second=0, res_count=3, res_src=1.
- After reset, s0 and s1 both valid continuously with 2-beat frames -> grant order s0, s1, s0, s1; the non-granted ready is never 1.
- res_ready held 0 for 3 cycles in REPORT -> res_valid stays 1 with fields stable; s0_ready=s1_ready=0; no beats accepted; IDLE on the 4th-cycle handshake.
- Single-beat frame s0 [0xFF] with last=1 -> res_max=0xFF, res_second_vld=0, res_count=1.
- Reset asserted after 2 beats of an s1 frame -> next cycle all outputs 0 and state IDLE; with both sources then valid, s0 is granted first and no stale result appears.
